// File: rtl/calc_mc.sv
// Multi-cycle unsigned calculator: add/sub/mul/min/max in one cycle, iterative div/mod,
// error flag for divide-by-zero and reserved opcode, valid/stall handshake on both sides.
module calc_mc #(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [WIDTH-1:0]   inpA,
    input  logic [WIDTH-1:0]   inpB,
    input  logic [2:0]         inpOpType,
    input  logic               iValid,
    output logic               iStall,
    output logic [2*WIDTH-1:0] outC,
    output logic               oErr,
    output logic               oValid,
    input  logic               oStall
);

    localparam int unsigned W2    = 2 * WIDTH;
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_DIV = 3'b011;
    localparam logic [2:0] OP_MOD = 3'b100;
    localparam logic [2:0] OP_MIN = 3'b101;
    localparam logic [2:0] OP_MAX = 3'b110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_n;
    logic [W2-1:0]      out_q, out_n;
    logic               err_q, err_n;
    logic [WIDTH-1:0]   quo_q, quo_n;
    logic [WIDTH-1:0]   rem_q, rem_n;
    logic [WIDTH-1:0]   dvs_q, dvs_n;
    logic [CNT_W-1:0]   cnt_q, cnt_n;
    logic               mod_q, mod_n;

    logic [W2-1:0]      sc_res;
    logic               sc_err;
    logic               div_start;
    logic               take;
    logic [WIDTH:0]     trial;
    logic               trial_ge;
    logic [WIDTH-1:0]   rem_step;
    logic [WIDTH-1:0]   quo_step;

    assign iStall = (state_q == DIV) || ((state_q == DONE) && oStall);
    assign take   = iValid && !iStall;
    assign outC   = out_q;
    assign oErr   = err_q;
    assign oValid = (state_q == DONE);

    // Single-cycle result; anything not listed (reserved, div/mod by zero) is an error
    always_comb begin
        sc_res = '0;
        sc_err = 1'b0;
        case (inpOpType)
            OP_ADD:  sc_res = W2'(inpA) + W2'(inpB);
            OP_SUB:  sc_res = W2'(inpA) - W2'(inpB);
            OP_MUL:  sc_res = W2'(inpA) * W2'(inpB);
            OP_MIN:  sc_res = W2'((inpA < inpB) ? inpA : inpB);
            OP_MAX:  sc_res = W2'((inpA > inpB) ? inpA : inpB);
            default: sc_err = 1'b1;
        endcase
    end

    assign div_start = ((inpOpType == OP_DIV) || (inpOpType == OP_MOD)) && (inpB != '0);

    // One restoring shift-subtract step: bring down the next dividend bit
    assign trial    = {rem_q, quo_q[WIDTH-1]};
    assign trial_ge = (trial >= {1'b0, dvs_q});
    assign rem_step = trial_ge ? WIDTH'(trial - {1'b0, dvs_q}) : trial[WIDTH-1:0];
    assign quo_step = {quo_q[WIDTH-2:0], trial_ge};

    always_comb begin
        state_n = state_q;
        out_n   = out_q;
        err_n   = err_q;
        quo_n   = quo_q;
        rem_n   = rem_q;
        dvs_n   = dvs_q;
        cnt_n   = cnt_q;
        mod_n   = mod_q;

        case (state_q)
            DIV: begin
                quo_n = quo_step;
                rem_n = rem_step;
                cnt_n = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    out_n   = mod_q ? W2'(rem_step) : W2'(quo_step);
                    err_n   = 1'b0;
                    state_n = DONE;
                end
            end
            DONE: begin
                if (!oStall) state_n = IDLE;
            end
            default: ;
        endcase

        // Accept overrides the consume-to-IDLE path so results can stream back to back
        if (take) begin
            if (div_start) begin
                quo_n   = inpA;
                rem_n   = '0;
                dvs_n   = inpB;
                cnt_n   = CNT_W'(WIDTH);
                mod_n   = (inpOpType == OP_MOD);
                state_n = DIV;
            end else begin
                out_n   = sc_res;
                err_n   = sc_err;
                state_n = DONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            out_q   <= '0;
            err_q   <= 1'b0;
            quo_q   <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            mod_q   <= 1'b0;
        end else begin
            state_q <= state_n;
            out_q   <= out_n;
            err_q   <= err_n;
            quo_q   <= quo_n;
            rem_q   <= rem_n;
            dvs_q   <= dvs_n;
            cnt_q   <= cnt_n;
            mod_q   <= mod_n;
        end
    end

endmodule

// File: tb/tb_calc_mc.sv
// Bench for calc_mc: directed scenarios plus random ops checked against an arithmetic model.
module tb_calc_mc;

    logic        clk = 1'b0;
    logic        rstn;
    logic [7:0]  inpA, inpB;
    logic [2:0]  inpOpType;
    logic        iValid, iStall;
    logic [15:0] outC;
    logic        oErr, oValid, oStall;

    logic [15:0] a16, b16;
    logic [2:0]  op16;
    logic        v16, s16_in, s16_out, e16, ov16;
    logic [31:0] c16;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_res;
    logic        exp_err;

    always #5 clk = ~clk;

    calc_mc #(.WIDTH(8)) dut (
        .clk(clk), .rstn(rstn), .inpA(inpA), .inpB(inpB), .inpOpType(inpOpType),
        .iValid(iValid), .iStall(iStall), .outC(outC), .oErr(oErr),
        .oValid(oValid), .oStall(oStall)
    );

    calc_mc #(.WIDTH(16)) dut16 (
        .clk(clk), .rstn(rstn), .inpA(a16), .inpB(b16), .inpOpType(op16),
        .iValid(v16), .iStall(s16_out), .outC(c16), .oErr(e16),
        .oValid(ov16), .oStall(s16_in)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected {err, result} straight from the opcode definitions
    function automatic logic [16:0] model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        int unsigned ai = a;
        int unsigned bi = b;
        logic [15:0] r = '0;
        logic        e = 1'b0;
        case (op)
            3'd0: r = 16'(ai + bi);
            3'd1: r = 16'(ai - bi);
            3'd2: r = 16'(ai * bi);
            3'd3: if (bi == 0) e = 1'b1; else r = 16'(ai / bi);
            3'd4: if (bi == 0) e = 1'b1; else r = 16'(ai % bi);
            3'd5: r = 16'((ai < bi) ? ai : bi);
            3'd6: r = 16'((ai > bi) ? ai : bi);
            default: e = 1'b1;
        endcase
        return {e, r};
    endfunction

    // Issue one op (DUT must be able to accept), wait for its result, check latency and value
    task automatic run_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, input string tag);
        logic [16:0] m;
        int exp_lat;
        int n;
        m       = model(op, a, b);
        exp_err = m[16];
        exp_res = m[15:0];
        exp_lat = ((op == 3'd3 || op == 3'd4) && b != 0) ? 9 : 1;
        inpA = a; inpB = b; inpOpType = op; iValid = 1'b1; oStall = 1'b0;
        #1;
        chk({tag, ".istall_pre"}, 64'(iStall), 64'(0));
        @(posedge clk); #1;
        iValid = 1'b0;
        n = 1;
        while (!oValid && n < 40) begin
            chk({tag, ".istall_busy"}, 64'(iStall), 64'(1));
            @(posedge clk); #1;
            n++;
        end
        chk({tag, ".ovalid"}, 64'(oValid), 64'(1));
        chk({tag, ".latency"}, 64'(n), 64'(exp_lat));
        chk({tag, ".outc"}, 64'(outC), 64'(exp_res));
        chk({tag, ".oerr"}, 64'(oErr), 64'(exp_err));
    endtask

    initial begin
        rstn = 1'b0; inpA = '0; inpB = '0; inpOpType = '0; iValid = 1'b0; oStall = 1'b0;
        a16 = '0; b16 = '0; op16 = '0; v16 = 1'b0; s16_in = 1'b0;
        #12;
        chk("rst.outc", 64'(outC), 64'(0));
        chk("rst.ovalid", 64'(oValid), 64'(0));
        chk("rst.oerr", 64'(oErr), 64'(0));
        chk("rst.istall", 64'(iStall), 64'(0));
        @(negedge clk); rstn = 1'b1;
        @(posedge clk); #1;

        // Back-to-back single-cycle ops
        run_op(3'd0, 8'h05, 8'h05, "add");
        chk("add.val", 64'(outC), 64'h000A);
        run_op(3'd1, 8'h05, 8'h08, "sub");
        chk("sub.val", 64'(outC), 64'hFFFD);
        run_op(3'd2, 8'h07, 8'h11, "mul");
        chk("mul.val", 64'(outC), 64'h0077);
        run_op(3'd3, 8'h16, 8'h02, "div");
        chk("div.val", 64'(outC), 64'h000B);
        run_op(3'd4, 8'h17, 8'h05, "mod");
        chk("mod.val", 64'(outC), 64'h0003);
        run_op(3'd3, 8'h16, 8'h00, "div0");
        run_op(3'd4, 8'h16, 8'h00, "mod0");
        run_op(3'd7, 8'h12, 8'h34, "rsvd");
        run_op(3'd5, 8'h80, 8'h7F, "min");
        run_op(3'd6, 8'h80, 8'h7F, "max");
        run_op(3'd3, 8'hFF, 8'h01, "div_by1");
        run_op(3'd4, 8'h03, 8'hFF, "mod_small");

        // Backpressure: held result, pending op not taken until release
        run_op(3'd0, 8'h03, 8'h04, "bp");
        oStall = 1'b1;
        inpA = 8'h01; inpB = 8'h01; inpOpType = 3'd0; iValid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("bp.hold_outc", 64'(outC), 64'h0007);
            chk("bp.hold_valid", 64'(oValid), 64'(1));
            chk("bp.istall", 64'(iStall), 64'(1));
        end
        oStall = 1'b0;
        @(posedge clk); #1;
        iValid = 1'b0;
        chk("bp.next_outc", 64'(outC), 64'h0002);
        chk("bp.next_valid", 64'(oValid), 64'(1));
        @(posedge clk); #1;
        chk("bp.drained", 64'(oValid), 64'(0));

        // Asynchronous reset in the middle of a divide
        inpA = 8'hFF; inpB = 8'h03; inpOpType = 3'd3; iValid = 1'b1;
        @(posedge clk); #1;
        iValid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        rstn = 1'b0;
        #1;
        chk("rstdiv.ovalid", 64'(oValid), 64'(0));
        chk("rstdiv.outc", 64'(outC), 64'(0));
        chk("rstdiv.istall", 64'(iStall), 64'(0));
        #2 rstn = 1'b1;
        @(posedge clk); #1;
        run_op(3'd0, 8'h01, 8'h02, "post_rst");

        // Wide instance full-scale multiply
        a16 = 16'hFFFF; b16 = 16'hFFFF; op16 = 3'd2; v16 = 1'b1;
        @(posedge clk); #1;
        v16 = 1'b0;
        chk("w16.ovalid", 64'(ov16), 64'(1));
        chk("w16.mul", 64'(c16), 64'(64'hFFFF * 64'hFFFF));
        chk("w16.oerr", 64'(e16), 64'(0));

        // Random ops with occasional consumer stalls
        for (int i = 0; i < 150; i++) begin
            logic [2:0] op;
            logic [7:0] a, b;
            op = 3'($urandom_range(0, 7));
            a  = 8'($urandom);
            b  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            run_op(op, a, b, "rand");
            if ($urandom_range(0, 1) == 1) begin
                oStall = 1'b1;
                repeat ($urandom_range(1, 3)) begin
                    @(posedge clk); #1;
                    chk("rand.stall_outc", 64'(outC), 64'(exp_res));
                    chk("rand.stall_valid", 64'(oValid), 64'(1));
                end
                oStall = 1'b0;
            end
        end

        @(posedge clk); #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
